// File: rtl/sdram_pkg.sv
// -----------------------------------------------------------------------------
// sdram_pkg
//   Shared definitions for the SDRAM controller:
//     - default bus widths
//     - SDRAM command encodings {cs_n, ras_n, cas_n, we_n}
//     - arbiter state encoding
//     - fixed-priority grant helper used by the arbiter
//   No ports (package).
// -----------------------------------------------------------------------------
package sdram_pkg;

    localparam int ADDR_W_DEF = 13;
    localparam int BA_W_DEF   = 2;
    localparam int DQ_W_DEF   = 16;

    // Command pin encodings {cs_n, ras_n, cas_n, we_n}
    localparam logic [3:0] CMD_NOP  = 4'b0111;
    localparam logic [3:0] CMD_PRE  = 4'b0010;
    localparam logic [3:0] CMD_AREF = 4'b0001;
    localparam logic [3:0] CMD_MRS  = 4'b0000;
    localparam logic [3:0] CMD_ACT  = 4'b0011;
    localparam logic [3:0] CMD_WR   = 4'b0100;
    localparam logic [3:0] CMD_RD   = 4'b0101;

    // Arbiter state encoding
    localparam logic [2:0] ST_INIT  = 3'd0;
    localparam logic [2:0] ST_ARBIT = 3'd1;
    localparam logic [2:0] ST_AREF  = 3'd2;
    localparam logic [2:0] ST_WRITE = 3'd3;
    localparam logic [2:0] ST_READ  = 3'd4;

    // Fixed priority: refresh > write > read. Returns ST_ARBIT when idle.
    function automatic logic [2:0] grant_state(input logic aref_req,
                                               input logic wr_req,
                                               input logic rd_req);
        if (aref_req)    return ST_AREF;
        else if (wr_req) return ST_WRITE;
        else if (rd_req) return ST_READ;
        else             return ST_ARBIT;
    endfunction

endpackage

// File: rtl/sdram_cmd_mux.sv
// -----------------------------------------------------------------------------
// sdram_cmd_mux
//   Purely combinational selection of the SDRAM command, bank and address
//   according to the arbiter state. ARBIT (and any unused encoding) drives
//   NOP with bank/address all ones.
//
//   Ports:
//     state                        in   current arbiter state
//     init_/aref_/wr_/rd_cmd       in   engine commands (4 bits each)
//     init_/aref_/wr_/rd_ba        in   engine bank addresses (BA_W)
//     init_/aref_/wr_/rd_addr      in   engine addresses (ADDR_W)
//     cmd                          out  selected {cs_n,ras_n,cas_n,we_n}
//     ba                           out  selected bank address
//     addr                         out  selected address
// -----------------------------------------------------------------------------
module sdram_cmd_mux
    import sdram_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int BA_W   = BA_W_DEF
) (
    input  logic [2:0]        state,
    input  logic [3:0]        init_cmd,
    input  logic [BA_W-1:0]   init_ba,
    input  logic [ADDR_W-1:0] init_addr,
    input  logic [3:0]        aref_cmd,
    input  logic [BA_W-1:0]   aref_ba,
    input  logic [ADDR_W-1:0] aref_addr,
    input  logic [3:0]        wr_cmd,
    input  logic [BA_W-1:0]   wr_ba,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [3:0]        rd_cmd,
    input  logic [BA_W-1:0]   rd_ba,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [3:0]        cmd,
    output logic [BA_W-1:0]   ba,
    output logic [ADDR_W-1:0] addr
);

    always_comb begin
        // NOTE: every output gets a default before the case so no path
        // leaves it unassigned, which would infer a latch.
        cmd  = CMD_NOP;
        ba   = '1;
        addr = '1;
        case (state)
            ST_INIT: begin
                cmd  = init_cmd;
                ba   = init_ba;
                addr = init_addr;
            end
            ST_AREF: begin
                cmd  = aref_cmd;
                ba   = aref_ba;
                addr = aref_addr;
            end
            ST_WRITE: begin
                cmd  = wr_cmd;
                ba   = wr_ba;
                addr = wr_addr;
            end
            ST_READ: begin
                cmd  = rd_cmd;
                ba   = rd_ba;
                addr = rd_addr;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/sdram_arbiter.sv
// -----------------------------------------------------------------------------
// sdram_arbiter
//   Grants the SDRAM command bus to one of init, auto-refresh, write or read.
//   Runs a req/en/end handshake with the refresh, write and read engines and
//   multiplexes the granted engine's command, bank and address onto the pins.
//   No preemption: write/read engines watch aref_req and close their burst.
//
//   Configuration macro: SDRAM_ARBITER_READ_EN
//     defined   - READ state and read handshake are built
//     undefined - rd_en tied 0, rd_* inputs ignored (ports kept)
//
//   Ports:
//     clk, rst                     in   clock, synchronous active-high reset
//     init_cmd/ba/addr, init_end   in   init engine command and done level
//     aref_req/end/cmd/ba/addr     in   refresh engine handshake and command
//     aref_en                      out  refresh grant
//     wr_req/end/cmd/ba/addr       in   write engine handshake and command
//     wr_en                        out  write grant
//     wr_sdram_en, wr_sdram_data   in   write data drive request and data
//     rd_req/end/cmd/ba/addr       in   read engine handshake and command
//     rd_en                        out  read grant
//     sdram_cke                    out  clock enable (constant 1)
//     sdram_cs_n/ras_n/cas_n/we_n  out  command pins
//     sdram_ba, sdram_addr         out  bank and address pins
//     sdram_dq_out, sdram_dq_oe    out  write data and output enable
// -----------------------------------------------------------------------------
module sdram_arbiter
    import sdram_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int BA_W   = BA_W_DEF,
    parameter int DQ_W   = DQ_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [3:0]        init_cmd,
    input  logic [BA_W-1:0]   init_ba,
    input  logic [ADDR_W-1:0] init_addr,
    input  logic              init_end,
    input  logic              aref_req,
    input  logic              aref_end,
    input  logic [3:0]        aref_cmd,
    input  logic [BA_W-1:0]   aref_ba,
    input  logic [ADDR_W-1:0] aref_addr,
    output logic              aref_en,
    input  logic              wr_req,
    input  logic              wr_end,
    output logic              wr_en,
    input  logic [3:0]        wr_cmd,
    input  logic [BA_W-1:0]   wr_ba,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic              wr_sdram_en,
    input  logic [DQ_W-1:0]   wr_sdram_data,
    input  logic              rd_req,
    input  logic              rd_end,
    output logic              rd_en,
    input  logic [3:0]        rd_cmd,
    input  logic [BA_W-1:0]   rd_ba,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              sdram_cke,
    output logic              sdram_cs_n,
    output logic              sdram_ras_n,
    output logic              sdram_cas_n,
    output logic              sdram_we_n,
    output logic [BA_W-1:0]   sdram_ba,
    output logic [ADDR_W-1:0] sdram_addr,
    output logic [DQ_W-1:0]   sdram_dq_out,
    output logic              sdram_dq_oe
);

    logic [2:0] state;
    logic [2:0] next_state;
    logic [3:0] cmd;
    logic       rd_req_eff;
    logic       rd_end_eff;

`ifdef SDRAM_ARBITER_READ_EN
    assign rd_req_eff = rd_req;
    assign rd_end_eff = rd_end;
`else
    // Read path not built: requests can never reach READ.
    assign rd_req_eff = 1'b0;
    assign rd_end_eff = 1'b0;
    logic unused_rd;
    assign unused_rd = rd_req ^ rd_end;
`endif

    // Requests are looked at only in ARBIT; *_end only from the granted
    // source, so stray ends and late init_end changes have no effect.
    always_comb begin
        next_state = state;
        case (state)
            ST_INIT:  if (init_end)   next_state = ST_ARBIT;
            ST_ARBIT: next_state = grant_state(aref_req, wr_req, rd_req_eff);
            ST_AREF:  if (aref_end)   next_state = ST_ARBIT;
            ST_WRITE: if (wr_end)     next_state = ST_ARBIT;
            ST_READ:  if (rd_end_eff) next_state = ST_ARBIT;
            default:  next_state = ST_INIT;
        endcase
    end

    // Grants are decoded from next_state so each one is a flop that is high
    // exactly while its state is held.
    always_ff @(posedge clk) begin
        // NOTE: synchronous reset inside the clocked block, and non-blocking
        // assignments so every flop samples pre-edge values.
        if (rst) begin
            state   <= ST_INIT;
            aref_en <= 1'b0;
            wr_en   <= 1'b0;
        end else begin
            state   <= next_state;
            aref_en <= (next_state == ST_AREF);
            wr_en   <= (next_state == ST_WRITE);
        end
    end

`ifdef SDRAM_ARBITER_READ_EN
    always_ff @(posedge clk) begin
        if (rst) rd_en <= 1'b0;
        else     rd_en <= (next_state == ST_READ);
    end
`else
    assign rd_en = 1'b0;
`endif

    sdram_cmd_mux #(
        .ADDR_W (ADDR_W),
        .BA_W   (BA_W)
    ) u_cmd_mux (
        .state     (state),
        .init_cmd  (init_cmd),
        .init_ba   (init_ba),
        .init_addr (init_addr),
        .aref_cmd  (aref_cmd),
        .aref_ba   (aref_ba),
        .aref_addr (aref_addr),
        .wr_cmd    (wr_cmd),
        .wr_ba     (wr_ba),
        .wr_addr   (wr_addr),
        .rd_cmd    (rd_cmd),
        .rd_ba     (rd_ba),
        .rd_addr   (rd_addr),
        .cmd       (cmd),
        .ba        (sdram_ba),
        .addr      (sdram_addr)
    );

    assign {sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n} = cmd;
    assign sdram_cke    = 1'b1;
    assign sdram_dq_oe  = (state == ST_WRITE) && wr_sdram_en;
    assign sdram_dq_out = sdram_dq_oe ? wr_sdram_data : '0;

endmodule

// File: tb/tb_sdram_arbiter.sv
// -----------------------------------------------------------------------------
// tb_sdram_arbiter
//   Directed testbench for sdram_arbiter. Inputs change 1 ns after a rising
//   edge; outputs are sampled 1 ns after the rising edge.
// -----------------------------------------------------------------------------
module tb_sdram_arbiter;
    import sdram_pkg::*;

    localparam int ADDR_W = 13;
    localparam int BA_W   = 2;
    localparam int DQ_W   = 16;

    localparam logic [3:0]        INIT_CMD  = CMD_PRE;
    localparam logic [BA_W-1:0]   INIT_BA   = 2'b01;
    localparam logic [ADDR_W-1:0] INIT_ADDR = 13'h0400;
    localparam logic [BA_W-1:0]   AREF_BA   = 2'b00;
    localparam logic [ADDR_W-1:0] AREF_ADDR = 13'h0123;
    localparam logic [BA_W-1:0]   WR_BA     = 2'b10;
    localparam logic [ADDR_W-1:0] WR_ADDR   = 13'h0aaa;
    localparam logic [BA_W-1:0]   RD_BA     = 2'b11;
    localparam logic [ADDR_W-1:0] RD_ADDR   = 13'h0555;

    logic              clk = 1'b0;
    logic              rst;
    logic [3:0]        init_cmd;
    logic [BA_W-1:0]   init_ba;
    logic [ADDR_W-1:0] init_addr;
    logic              init_end;
    logic              aref_req, aref_end, aref_en;
    logic [3:0]        aref_cmd;
    logic [BA_W-1:0]   aref_ba;
    logic [ADDR_W-1:0] aref_addr;
    logic              wr_req, wr_end, wr_en;
    logic [3:0]        wr_cmd;
    logic [BA_W-1:0]   wr_ba;
    logic [ADDR_W-1:0] wr_addr;
    logic              wr_sdram_en;
    logic [DQ_W-1:0]   wr_sdram_data;
    logic              rd_req, rd_end, rd_en;
    logic [3:0]        rd_cmd;
    logic [BA_W-1:0]   rd_ba;
    logic [ADDR_W-1:0] rd_addr;
    logic              sdram_cke, sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n;
    logic [BA_W-1:0]   sdram_ba;
    logic [ADDR_W-1:0] sdram_addr;
    logic [DQ_W-1:0]   sdram_dq_out;
    logic              sdram_dq_oe;

    int n_cmp = 0;
    int n_err = 0;

    // Packed view of everything on the pins: {cmd, ba, addr}
    logic [3+BA_W+ADDR_W:0] pins;
    assign pins = {sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n, sdram_ba, sdram_addr};
    // Grants packed as {aref_en, wr_en, rd_en}
    logic [2:0] grants;
    assign grants = {aref_en, wr_en, rd_en};

    localparam logic [3+BA_W+ADDR_W:0] P_INIT = {INIT_CMD, INIT_BA, INIT_ADDR};
    localparam logic [3+BA_W+ADDR_W:0] P_NOP  = {CMD_NOP, 2'b11, 13'h1fff};
    localparam logic [3+BA_W+ADDR_W:0] P_AREF = {CMD_AREF, AREF_BA, AREF_ADDR};
    localparam logic [3+BA_W+ADDR_W:0] P_WR   = {CMD_WR, WR_BA, WR_ADDR};
    localparam logic [3+BA_W+ADDR_W:0] P_RD   = {CMD_RD, RD_BA, RD_ADDR};

    always #5 clk = ~clk;

    sdram_arbiter #(.ADDR_W(ADDR_W), .BA_W(BA_W), .DQ_W(DQ_W)) dut (
        .clk           (clk),
        .rst           (rst),
        .init_cmd      (init_cmd),
        .init_ba       (init_ba),
        .init_addr     (init_addr),
        .init_end      (init_end),
        .aref_req      (aref_req),
        .aref_end      (aref_end),
        .aref_cmd      (aref_cmd),
        .aref_ba       (aref_ba),
        .aref_addr     (aref_addr),
        .aref_en       (aref_en),
        .wr_req        (wr_req),
        .wr_end        (wr_end),
        .wr_en         (wr_en),
        .wr_cmd        (wr_cmd),
        .wr_ba         (wr_ba),
        .wr_addr       (wr_addr),
        .wr_sdram_en   (wr_sdram_en),
        .wr_sdram_data (wr_sdram_data),
        .rd_req        (rd_req),
        .rd_end        (rd_end),
        .rd_en         (rd_en),
        .rd_cmd        (rd_cmd),
        .rd_ba         (rd_ba),
        .rd_addr       (rd_addr),
        .sdram_cke     (sdram_cke),
        .sdram_cs_n    (sdram_cs_n),
        .sdram_ras_n   (sdram_ras_n),
        .sdram_cas_n   (sdram_cas_n),
        .sdram_we_n    (sdram_we_n),
        .sdram_ba      (sdram_ba),
        .sdram_addr    (sdram_addr),
        .sdram_dq_out  (sdram_dq_out),
        .sdram_dq_oe   (sdram_dq_oe)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        n_cmp++; if (grants !== 3'b000) begin n_err++; $display("FAIL reset_grants: got %b want 000", grants); end
        n_cmp++; if (sdram_dq_oe !== 1'b0) begin n_err++; $display("FAIL reset_dq_oe: got %b want 0", sdram_dq_oe); end
        n_cmp++; if (sdram_dq_out !== 16'h0) begin n_err++; $display("FAIL reset_dq_out: got %h want 0000", sdram_dq_out); end
        n_cmp++; if (sdram_cke !== 1'b1) begin n_err++; $display("FAIL reset_cke: got %b want 1", sdram_cke); end
        n_cmp++; if (pins !== P_INIT) begin n_err++; $display("FAIL reset_pins: got %h want %h", pins, P_INIT); end
        rst = 1'b0;
        // init_end stays low for 10 cycles after release; pins follow init_*.
        for (int i = 0; i < 10; i++) begin
            tick();
            n_cmp++; if (pins !== P_INIT || grants !== 3'b000) begin
                n_err++; $display("FAIL init_hold[%0d]: got pins %h grants %b want %h 000", i, pins, grants, P_INIT);
            end
        end
        init_end = 1'b1;
        tick();
        n_cmp++; if (pins !== P_NOP) begin n_err++; $display("FAIL arbit_nop: got %h want %h", pins, P_NOP); end
        // init_end dropping after INIT must not matter.
        init_end = 1'b0;
        tick();
        n_cmp++; if (pins !== P_NOP) begin n_err++; $display("FAIL init_end_fall: got %h want %h", pins, P_NOP); end
    endtask

    task automatic test_aref();
        aref_req = 1'b1;
        tick();
        n_cmp++; if (grants !== 3'b100) begin n_err++; $display("FAIL aref_grant: got %b want 100", grants); end
        n_cmp++; if (pins !== P_AREF) begin n_err++; $display("FAIL aref_pins: got %h want %h", pins, P_AREF); end
        // A foreign end pulse is ignored.
        wr_end = 1'b1;
        tick();
        wr_end = 1'b0;
        n_cmp++; if (grants !== 3'b100) begin n_err++; $display("FAIL aref_foreign_end: got %b want 100", grants); end
        aref_end = 1'b1;
        aref_req = 1'b0;
        tick();
        aref_end = 1'b0;
        n_cmp++; if (grants !== 3'b000 || pins !== P_NOP) begin
            n_err++; $display("FAIL aref_release: got %b %h want 000 %h", grants, pins, P_NOP);
        end
    endtask

    task automatic test_priority();
        aref_req = 1'b1; wr_req = 1'b1; rd_req = 1'b1;
        tick();
        n_cmp++; if (grants !== 3'b100) begin n_err++; $display("FAIL prio_first: got %b want 100", grants); end
        aref_end = 1'b1; aref_req = 1'b0;
        tick();
        aref_end = 1'b0;
        n_cmp++; if (grants !== 3'b000 || pins !== P_NOP) begin
            n_err++; $display("FAIL prio_gap1: got %b %h want 000 %h", grants, pins, P_NOP);
        end
        tick();
        n_cmp++; if (grants !== 3'b010 || pins !== P_WR) begin
            n_err++; $display("FAIL prio_second: got %b %h want 010 %h", grants, pins, P_WR);
        end
        wr_end = 1'b1; wr_req = 1'b0;
        tick();
        wr_end = 1'b0;
        n_cmp++; if (grants !== 3'b000 || pins !== P_NOP) begin
            n_err++; $display("FAIL prio_gap2: got %b %h want 000 %h", grants, pins, P_NOP);
        end
        tick();
`ifdef SDRAM_ARBITER_READ_EN
        n_cmp++; if (grants !== 3'b001 || pins !== P_RD) begin
            n_err++; $display("FAIL prio_third: got %b %h want 001 %h", grants, pins, P_RD);
        end
        rd_end = 1'b1; rd_req = 1'b0;
        tick();
        rd_end = 1'b0;
        n_cmp++; if (grants !== 3'b000 || pins !== P_NOP) begin
            n_err++; $display("FAIL prio_gap3: got %b %h want 000 %h", grants, pins, P_NOP);
        end
`else
        n_cmp++; if (grants !== 3'b000 || pins !== P_NOP) begin
            n_err++; $display("FAIL prio_no_read: got %b %h want 000 %h", grants, pins, P_NOP);
        end
        rd_req = 1'b0;
`endif
    endtask

    task automatic test_back_to_back();
        // End with own request still high: one NOP cycle, then re-grant.
        wr_req = 1'b1;
        tick();
        wr_end = 1'b1;
        tick();
        wr_end = 1'b0;
        n_cmp++; if (grants !== 3'b000 || pins !== P_NOP) begin
            n_err++; $display("FAIL b2b_gap: got %b %h want 000 %h", grants, pins, P_NOP);
        end
        tick();
        n_cmp++; if (grants !== 3'b010) begin n_err++; $display("FAIL b2b_regrant: got %b want 010", grants); end
        wr_end = 1'b1; wr_req = 1'b0;
        tick();
        wr_end = 1'b0;
    endtask

    task automatic test_write_data();
        int bad;
        wr_req = 1'b1;
        wr_sdram_data = 16'hA5A5;
        tick();
        n_cmp++; if (wr_en !== 1'b1 || sdram_dq_oe !== 1'b0 || sdram_dq_out !== 16'h0) begin
            n_err++; $display("FAIL wdata_idle: got en %b oe %b dq %h want 1 0 0000", wr_en, sdram_dq_oe, sdram_dq_out);
        end
        bad = 0;
        for (int i = 0; i < 4; i++) begin
            wr_sdram_en = 1'b1;
            tick();
            if (sdram_dq_oe !== 1'b1 || sdram_dq_out !== 16'hA5A5) bad++;
        end
        n_cmp++; if (bad != 0) begin n_err++; $display("FAIL wdata_drive: got %0d bad cycles want 0 (last oe %b dq %h)", bad, sdram_dq_oe, sdram_dq_out); end
        wr_sdram_en = 1'b0;
        tick();
        n_cmp++; if (sdram_dq_oe !== 1'b0 || sdram_dq_out !== 16'h0) begin
            n_err++; $display("FAIL wdata_off: got oe %b dq %h want 0 0000", sdram_dq_oe, sdram_dq_out);
        end
        wr_end = 1'b1; wr_req = 1'b0; wr_sdram_en = 1'b1;
        tick();
        wr_end = 1'b0;
        n_cmp++; if (sdram_dq_oe !== 1'b0 || sdram_dq_out !== 16'h0) begin
            n_err++; $display("FAIL wdata_arbit: got oe %b dq %h want 0 0000", sdram_dq_oe, sdram_dq_out);
        end
`ifdef SDRAM_ARBITER_READ_EN
        rd_req = 1'b1;
        tick();
        n_cmp++; if (rd_en !== 1'b1 || sdram_dq_oe !== 1'b0 || sdram_dq_out !== 16'h0) begin
            n_err++; $display("FAIL wdata_read: got en %b oe %b dq %h want 1 0 0000", rd_en, sdram_dq_oe, sdram_dq_out);
        end
        rd_end = 1'b1; rd_req = 1'b0;
        tick();
        rd_end = 1'b0;
`endif
        wr_sdram_en = 1'b0;
    endtask

    task automatic test_reset_mid_write();
        int bad;
        wr_req = 1'b1; wr_sdram_en = 1'b1;
        tick();
        n_cmp++; if (wr_en !== 1'b1 || sdram_dq_oe !== 1'b1) begin
            n_err++; $display("FAIL rmw_setup: got en %b oe %b want 1 1", wr_en, sdram_dq_oe);
        end
        rst = 1'b1; init_end = 1'b1;
        tick();
        n_cmp++; if (grants !== 3'b000 || sdram_dq_oe !== 1'b0 || pins !== P_INIT) begin
            n_err++; $display("FAIL rmw_reset: got %b oe %b %h want 000 0 %h", grants, sdram_dq_oe, pins, P_INIT);
        end
        rst = 1'b0; init_end = 1'b0;
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (grants !== 3'b000 || pins !== P_INIT) bad++;
        end
        n_cmp++; if (bad != 0) begin n_err++; $display("FAIL rmw_wait_init: got %0d bad cycles want 0", bad); end
        init_end = 1'b1;
        tick();
        n_cmp++; if (grants !== 3'b000 || pins !== P_NOP) begin
            n_err++; $display("FAIL rmw_arbit: got %b %h want 000 %h", grants, pins, P_NOP);
        end
        tick();
        n_cmp++; if (wr_en !== 1'b1 || pins !== P_WR) begin
            n_err++; $display("FAIL rmw_regrant: got %b %h want 1 %h", wr_en, pins, P_WR);
        end
        wr_end = 1'b1; wr_req = 1'b0; wr_sdram_en = 1'b0;
        tick();
        wr_end = 1'b0;
    endtask

`ifndef SDRAM_ARBITER_READ_EN
    task automatic test_read_disabled();
        int bad;
        bad = 0;
        rd_req = 1'b1;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (rd_en !== 1'b0 || pins !== P_NOP) bad++;
        end
        n_cmp++; if (bad != 0) begin n_err++; $display("FAIL read_disabled: got %0d bad cycles want 0", bad); end
        rd_end = 1'b1;
        tick();
        rd_end = 1'b0; rd_req = 1'b0;
        n_cmp++; if (grants !== 3'b000 || pins !== P_NOP) begin
            n_err++; $display("FAIL read_disabled_end: got %b %h want 000 %h", grants, pins, P_NOP);
        end
    endtask
`endif

    initial begin
        rst = 1'b1;
        init_cmd = INIT_CMD; init_ba = INIT_BA; init_addr = INIT_ADDR; init_end = 1'b0;
        aref_req = 1'b0; aref_end = 1'b0;
        aref_cmd = CMD_AREF; aref_ba = AREF_BA; aref_addr = AREF_ADDR;
        wr_req = 1'b0; wr_end = 1'b0;
        wr_cmd = CMD_WR; wr_ba = WR_BA; wr_addr = WR_ADDR;
        wr_sdram_en = 1'b0; wr_sdram_data = 16'h0;
        rd_req = 1'b0; rd_end = 1'b0;
        rd_cmd = CMD_RD; rd_ba = RD_BA; rd_addr = RD_ADDR;

        test_reset();
        test_aref();
        test_priority();
        test_back_to_back();
        test_write_data();
        test_reset_mid_write();
`ifndef SDRAM_ARBITER_READ_EN
        test_read_disabled();
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/sdram_arbiter.md
# sdram_arbiter

Grants the SDRAM command bus to one of four command sources: init, auto-refresh, write, read. Answers the `sdram_aref` request/enable/end handshake with `aref_en`, and runs the same handshake toward the write and read engines. Multiplexes the granted source's command, bank and address onto the chip pins. Sits between those engines and the SDRAM device at the top of the controller.

## Interface
- `ADDR_W`, 13, SDRAM address width
- `BA_W`, 2, bank address width
- `DQ_W`, 16, data width
- `clk`  in  1  system clock, 100 MHz
- `rst`  in  1  reset; synchronous, active-high
- `init_cmd` in 4, `init_ba` in BA_W, `init_addr` in ADDR_W  init engine command, bank and address
- `init_end`  in  1  initialisation complete (level)
- `aref_req`  in  1  refresh request
- `aref_end`  in  1  refresh done (1-cycle pulse)
- `aref_cmd` in 4, `aref_ba` in BA_W, `aref_addr` in ADDR_W  refresh engine command, bank and address
- `aref_en`  out  1  refresh grant
- `wr_req`, `wr_end` in 1; `wr_en` out 1; `wr_cmd`, `wr_ba`, `wr_addr` in  write engine handshake and command
- `wr_sdram_en` in 1, `wr_sdram_data` in DQ_W  write data drive request and data
- `rd_req`, `rd_end` in 1; `rd_en` out 1; `rd_cmd`, `rd_ba`, `rd_addr` in  read engine handshake and command
- `sdram_cke`  out  1  clock enable
- `sdram_cs_n`, `sdram_ras_n`, `sdram_cas_n`, `sdram_we_n`  out  1 each  command pins
- `sdram_ba` out BA_W, `sdram_addr` out ADDR_W  bank and address pins
- `sdram_dq_out` out DQ_W, `sdram_dq_oe` out 1  data out and output enable; the top level builds the tristate

## Operation
- Command pins are `{cs_n,ras_n,cas_n,we_n}`. NOP is 4'b0111.
- States:
  - INIT (reset state): output the init_* inputs. Go to ARBIT when `init_end`=1.
  - ARBIT: output NOP, `sdram_ba` all ones, `sdram_addr` all ones. Grant in fixed priority `aref_req` > `wr_req` > `rd_req`: AREF, WRITE or READ respectively. Stay in ARBIT if no request.
  - AREF, WRITE, READ: output that engine's cmd, ba and addr. Return to ARBIT on the matching `*_end`.
- Each grant output is registered: high exactly while in its state. It rises the edge the state is entered and falls the edge after `*_end` is sampled.
- Requests are sampled only in ARBIT. Requests raised during another grant wait.
- No preemption. Write and read engines must watch `aref_req` themselves and close their burst.
- `sdram_dq_oe` = (state==WRITE) & `wr_sdram_en`. `sdram_dq_out` = `wr_sdram_data` when `sdram_dq_oe`=1, else 0.
- `sdram_cke` is constant 1.
- Reset values:
  - state INIT
  - all grants 0
  - `sdram_dq_oe` 0, `sdram_dq_out` 0
  - `sdram_cke` 1
  - Pins during reset show init_* (the init engine is itself in reset and drives NOP).

## Timing
- Pin mux is combinational from the registered state, so 0 added latency from an engine's command to the pins.
- Request to grant: 1 cycle. `*_req` sampled high in ARBIT at edge N gives grant high after edge N.
- End to next grant: at least 2 cycles. The edge that samples `*_end` gives ARBIT (one NOP cycle); the next edge can grant.
- `*_end` with its own `*_req` still high in the same cycle: go to ARBIT anyway, then re-grant by priority.
- `*_end` from a source that is not granted: ignored.
- `init_end` falling after INIT: ignored.
- `rst` mid-grant: the next edge forces INIT, all grants 0 and `sdram_dq_oe` 0, whatever the other inputs are.

## Configuration
- `SDRAM_ARBITER_READ_EN` defined: READ state and the read handshake are as described above.
- Undefined: READ state is not built and `rd_en` is tied 0. `rd_req`, `rd_end` and the rd_* command inputs are ignored. Priority is aref > write. The ports stay present.

## Structure
- Shared package `sdram_pkg` holds:
  - command constants: CMD_NOP 4'b0111, CMD_PRE 4'b0010, CMD_AREF 4'b0001, CMD_MRS 4'b0000, CMD_ACT 4'b0011, CMD_WR 4'b0100, CMD_RD 4'b0101
  - the arbiter state encoding (INIT, ARBIT, AREF, WRITE, READ)
  - default widths
- One sub-module, `sdram_cmd_mux`: purely combinational selection of cmd, ba and addr by state.
- FSM, grant registers and DQ enable stay in `sdram_arbiter`.

## Test plan
- Startup: `rst`=1 for 2 cycles, `init_end` rises 10 cycles after release → state INIT until then, pins follow init_*. ARBIT one cycle later, pins 4'b0111, addr 13'h1fff.
- Refresh handshake: `aref_req` held high in ARBIT → `aref_en`=1 one cycle later, pins follow aref_cmd (CMD_AREF). `aref_end` pulse → `aref_en`=0 next cycle, NOP.
- Priority: `aref_req`, `wr_req`, `rd_req` all rise the same cycle → grant order aref, write, read. Each separated by exactly one NOP cycle when every `*_end` and release comes promptly.
- Write data: in WRITE, `wr_sdram_en`=1 with data 16'hA5A5 for 4 cycles → `sdram_dq_oe`=1 and `sdram_dq_out`=16'hA5A5 in those cycles only. 0 elsewhere, and 0 in READ even with `wr_sdram_en`=1.
- Reset mid-write: assert `rst` while `wr_en`=1 → next edge `wr_en`=0, `sdram_dq_oe`=0, state INIT. No grant until `init_end`.
- Macro off: `SDRAM_ARBITER_READ_EN` undefined, `rd_req` held high 100 cycles → `rd_en` stays 0, pins stay NOP.
